// File: rtl/cell_particle_reader_if.sv
// Particle stream interface between the cell reader and its consumers.
// Ports (signals):
//   out_data  - particle word {posz, posy, posx}
//   out_index - cell memory address the word came from (1..N)
//   out_last  - final beat of the cell
//   out_valid - beat available (driven by master)
//   out_ready - consumer accepts (driven by slave); transfer on valid && ready
interface cell_particle_reader_if #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_index,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/cell_particle_reader.sv
// Read-side controller for one cell position RAM. Address 0 holds the particle
// count, addresses 1..N hold particle words. On start it reads the count, then
// streams every particle word out through a small skid FIFO that absorbs the
// two reads that can still be in flight when the consumer stalls.
// Ports:
//   clock, rst_n           - clock, asynchronous active-low reset
//   start                  - one-cycle pulse, ignored while busy
//   busy, done             - sequence in progress / one-cycle completion pulse
//   count_err              - stored count was above PARTICLE_NUM-1 (clamped)
//   mem_address, mem_rden  - registered read request to the RAM
//   mem_wren               - always 0, this block never writes
//   mem_q                  - RAM read data, 2 cycles after the rden cycle
//   out_if                 - particle stream (master side)
module cell_particle_reader #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   count_err,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic                   mem_rden,
  output logic                   mem_wren,
  input  logic [DATA_WIDTH-1:0]  mem_q,
  cell_particle_reader_if.master out_if
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] MaxCount = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {StIdle, StCntRd, StCntWait, StStream, StDrain} state_e;

  state_e state_q, state_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rden_q, rden_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [1:0]            in_flight_q, in_flight_d;

  // Read-return pipeline: stage 2 lines up with mem_q of that read.
  logic                  rd_p1_q, rd_p2_q;
  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p2_q;

  logic [DATA_WIDTH-1:0] fifo_data_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_index_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;

  logic                  push, pop;
  logic                  cnt_ready, count_over, last_issued, issue_ok, last_pop;
  logic [ADDR_WIDTH-1:0] raw_count, clamped_count;

  // Only data reads land in the FIFO; the count read returns in StCntWait.
  assign push      = rd_p2_q && ((state_q == StStream) || (state_q == StDrain));
  assign pop       = out_if.out_valid && out_if.out_ready;
  assign last_pop  = pop && out_if.out_last;
  assign cnt_ready = (state_q == StCntWait) && rd_p2_q;

  assign raw_count     = mem_q[ADDR_WIDTH-1:0];
  assign count_over    = raw_count > MaxCount;
  assign clamped_count = count_over ? MaxCount : raw_count;
  assign last_issued   = (addr_q == count_q);

  assign fifo_cnt_d  = fifo_cnt_q + CntW'(push) - CntW'(pop);
  assign wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
  assign rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
  // Reads outstanding next cycle: the one on the bus now plus the one after it.
  assign in_flight_d = {1'b0, rden_q} + {1'b0, rd_p1_q};
  // rden is registered, so judge room against next-cycle occupancy.
  assign issue_ok    = (32'(fifo_cnt_d) + 32'(in_flight_d)) < FIFO_DEPTH;

  // State register and registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rden_q      <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      addr_p1_q   <= '0;
      addr_p2_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rden_q      <= rden_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      rd_p1_q     <= rden_q;
      rd_p2_q     <= rd_p1_q;
      addr_p1_q   <= addr_q;
      addr_p2_q   <= addr_p1_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // FIFO storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q]  <= mem_q;
      fifo_index_q[wr_ptr_q] <= addr_p2_q;
      fifo_last_q[wr_ptr_q]  <= (addr_p2_q == count_q);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCntRd;
      StCntRd:   state_d = StCntWait;
      StCntWait: begin
        if (cnt_ready) state_d = (clamped_count == '0) ? StIdle : StStream;
      end
      StStream:  if (last_issued) state_d = StDrain;
      StDrain:   if (last_pop) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    rden_d  = 1'b0;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rden_d = 1'b1;
          addr_d = '0;
          err_d  = 1'b0;
        end
      end
      StCntWait: begin
        if (cnt_ready) begin
          count_d = clamped_count;
          err_d   = count_over;
          if (clamped_count == '0) begin
            done_d = 1'b1;
          end else begin
            // FIFO is empty here, so the first data read needs no room check.
            rden_d = 1'b1;
            addr_d = ADDR_WIDTH'(1);
          end
        end
      end
      StStream: begin
        if (!last_issued && issue_ok) begin
          rden_d = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      StDrain:  if (last_pop) done_d = 1'b1;
      default:  ;
    endcase
    // done shares its cycle with busy; a start in that cycle keeps busy up.
    busy_d = (state_d != StIdle) || done_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign count_err   = err_q;
  assign mem_address = addr_q;
  assign mem_rden    = rden_q;
  assign mem_wren    = 1'b0;

  assign out_if.out_valid = (fifo_cnt_q != '0);
  assign out_if.out_data  = out_if.out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_if.out_index = out_if.out_valid ? fifo_index_q[rd_ptr_q] : '0;
  assign out_if.out_last  = out_if.out_valid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_cell_particle_reader.sv
// Self-checking bench for cell_particle_reader: behavioural 2-cycle RAM, a
// scoreboard queue of expected beats, one task per scenario.
module tb_cell_particle_reader;
  localparam int unsigned DW = 96;
  localparam int unsigned PN = 220;
  localparam int unsigned AW = 8;
  localparam int unsigned FD = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, count_err, mem_rden, mem_wren;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_q;

  cell_particle_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out_if ();

  cell_particle_reader #(
    .DATA_WIDTH  (DW),
    .PARTICLE_NUM(PN),
    .ADDR_WIDTH  (AW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .count_err  (count_err),
    .mem_address(mem_address),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .out_if     (out_if)
  );

  always #5 clock = ~clock;

  // RAM model: data valid 2 cycles after the rden cycle, junk otherwise.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clock) begin
    rd1 <= mem_rden ? mem[mem_address] : {3{32'hDEAD_BEEF}};
    rd2 <= rd1;
  end
  assign mem_q = rd2;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic logic [DW-1:0] pat(int i);
    return {(32'(i) * 32'h0101_0101) ^ 32'hC0FF_EE00, 32'(i) + 32'h1000, 32'(i) + 32'hA0};
  endfunction

  // Fill the RAM with a count and patterns, queue reps copies of beats 1..n.
  task automatic load_cell(int raw, int n, int reps);
    mem[0] = DW'(raw);
    for (int i = 1; i < 256; i++) mem[i] = pat(i);
    for (int r = 0; r < reps; r++)
      for (int i = 1; i <= n; i++) exp_q.push_back('{data: pat(i), idx: AW'(i), last: (i == n)});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_if.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, done, count_err, mem_rden, mem_wren, out_if.out_valid, out_if.out_last} !== 7'b0)
      begin n_fail++; $display("FAIL reset_flags: got %b required 0000000",
        {busy, done, count_err, mem_rden, mem_wren, out_if.out_valid, out_if.out_last}); end
    n_checks++;
    if ({mem_address, out_if.out_index, out_if.out_data} !== '0) begin
      n_fail++; $display("FAIL reset_buses: got addr %0d index %0d data %h required 0",
        mem_address, out_if.out_index, out_if.out_data); end
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, mem_rden, out_if.out_valid} !== 3'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b required 000", {busy, mem_rden, out_if.out_valid});
    end
  endtask

  task automatic test_basic();
    beat_t b;
    logic  exp_rden;
    int    exp_addr;
    exp_q.delete();
    mem[0] = DW'(3); mem[1] = DW'('hA1); mem[2] = DW'('hA2); mem[3] = DW'('hA3);
    for (int i = 1; i <= 3; i++) exp_q.push_back('{data: mem[i], idx: AW'(i), last: (i == 3)});
    out_if.out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      start = (c == 0);
      exp_rden = (c == 1) || (c >= 4 && c <= 6);
      exp_addr = (c == 1) ? 0 : c - 3;
      n_checks++;
      if (mem_rden !== exp_rden) begin
        n_fail++; $display("FAIL basic_rden c%0d: got %b required %b", c, mem_rden, exp_rden); end
      if (exp_rden) begin
        n_checks++;
        if (mem_address !== AW'(exp_addr)) begin n_fail++;
          $display("FAIL basic_addr c%0d: got %0d required %0d", c, mem_address, exp_addr); end
      end
      n_checks++;
      if (busy !== (c >= 1 && c <= 10)) begin
        n_fail++; $display("FAIL basic_busy c%0d: got %b required %b", c, busy, c >= 1 && c <= 10);
      end
      n_checks++;
      if (done !== (c == 10)) begin
        n_fail++; $display("FAIL basic_done c%0d: got %b required %b", c, done, c == 10); end
      n_checks++;
      if (out_if.out_valid !== (c >= 7 && c <= 9)) begin n_fail++;
        $display("FAIL basic_valid c%0d: got %b required %b", c, out_if.out_valid, c >= 7 && c <= 9);
      end
      if (out_if.out_valid && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        n_checks++;
        if ({out_if.out_data, out_if.out_index, out_if.out_last} !== b) begin n_fail++;
          $display("FAIL basic_beat c%0d: got %h/%0d/%b required %h/%0d/%b", c, out_if.out_data,
            out_if.out_index, out_if.out_last, b.data, b.idx, b.last); end
      end
    end
    start = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_missing: got %0d beats left required 0", exp_q.size()); end
  endtask

  task automatic test_zero();
    exp_q.delete();
    load_cell(0, 0, 1);
    out_if.out_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      start = (c == 0);
      n_checks++;
      if (out_if.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL zero_valid c%0d: got %b required 0", c, out_if.out_valid); end
      n_checks++;
      if (done !== (c == 4)) begin
        n_fail++; $display("FAIL zero_done c%0d: got %b required %b", c, done, c == 4); end
      n_checks++;
      if (busy !== (c >= 1 && c <= 4)) begin
        n_fail++; $display("FAIL zero_busy c%0d: got %b required %b", c, busy, c >= 1 && c <= 4);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_backpressure();
    beat_t b, held;
    logic  stalled = 1'b0;
    logic  seen_done = 1'b0;
    exp_q.delete();
    load_cell(10, 10, 1);
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clock);
      start = (c == 0);
      out_if.out_ready = (c % 4 == 0) || (c % 4 == 3);
      if (stalled) begin
        n_checks++;
        if ({out_if.out_data, out_if.out_index, out_if.out_last} !== held) begin n_fail++;
          $display("FAIL bp_stable c%0d: got index %0d required %0d", c, out_if.out_index, held.idx);
        end
      end
      n_checks++;
      if (int'(dut.fifo_cnt_q) + int'(dut.in_flight_q) > int'(FD)) begin n_fail++;
        $display("FAIL bp_occupancy c%0d: got fifo %0d inflight %0d required sum <= %0d", c,
          dut.fifo_cnt_q, dut.in_flight_q, FD); end
      if (out_if.out_valid && out_if.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++;
          $display("FAIL bp_extra: got index %0d required no beat", out_if.out_index); end
        else begin
          b = exp_q.pop_front();
          if ({out_if.out_data, out_if.out_index, out_if.out_last} !== b) begin n_fail++;
            $display("FAIL bp_beat c%0d: got %h/%0d/%b required %h/%0d/%b", c, out_if.out_data,
              out_if.out_index, out_if.out_last, b.data, b.idx, b.last); end
        end
      end
      stalled = out_if.out_valid && !out_if.out_ready;
      held    = {out_if.out_data, out_if.out_index, out_if.out_last};
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (!seen_done || exp_q.size() != 0) begin n_fail++;
      $display("FAIL bp_complete: got done %b left %0d required done 1 left 0",
        seen_done, exp_q.size()); end
  endtask

  task automatic test_count_err();
    beat_t b;
    int    beats = 0;
    int    last_idx = -1;
    logic  seen_done = 1'b0;
    exp_q.delete();
    load_cell(250, PN - 1, 1);
    out_if.out_ready = 1'b1;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clock);
      start = (c == 0);
      if (out_if.out_valid) begin
        beats++;
        if (out_if.out_last) last_idx = int'(out_if.out_index);
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++;
          $display("FAIL err_extra: got index %0d required no beat", out_if.out_index); end
        else begin
          b = exp_q.pop_front();
          if ({out_if.out_data, out_if.out_index, out_if.out_last} !== b) begin n_fail++;
            $display("FAIL err_beat: got index %0d last %b required index %0d last %b",
              out_if.out_index, out_if.out_last, b.idx, b.last); end
        end
      end
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (!seen_done || beats != int'(PN) - 1 || last_idx != int'(PN) - 1) begin n_fail++;
      $display("FAIL err_count: got done %b beats %0d last %0d required 1/%0d/%0d",
        seen_done, beats, last_idx, PN - 1, PN - 1); end
    n_checks++;
    if (count_err !== 1'b1) begin
      n_fail++; $display("FAIL err_flag: got %b required 1", count_err); end
    load_cell(0, 0, 1);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n_checks++;
    if (count_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b required 0", count_err); end
    repeat (6) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    beat_t b;
    int    beats = 0;
    logic  seen_done = 1'b0;
    exp_q.delete();
    load_cell(8, 8, 1);
    out_if.out_ready = 1'b1;
    for (int c = 0; c < 40 && beats < 3; c++) begin
      @(negedge clock);
      start = (c == 0);
      if (out_if.out_valid) begin
        beats++;
        b = exp_q.pop_front();
        n_checks++;
        if ({out_if.out_data, out_if.out_index, out_if.out_last} !== b) begin n_fail++;
          $display("FAIL rst_pre_beat: got index %0d required %0d", out_if.out_index, b.idx); end
      end
    end
    start = 1'b0;
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, count_err, mem_rden, out_if.out_valid, out_if.out_last} !== 6'b0 ||
        {mem_address, out_if.out_index, out_if.out_data} !== '0) begin n_fail++;
      $display("FAIL rst_mid_outputs: got flags %b addr %0d index %0d required all 0",
        {busy, done, count_err, mem_rden, out_if.out_valid, out_if.out_last}, mem_address,
        out_if.out_index); end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      n_checks++;
      if ({out_if.out_valid, mem_rden, busy} !== 3'b0) begin n_fail++;
        $display("FAIL rst_quiet c%0d: got %b required 000", c, {out_if.out_valid, mem_rden, busy});
      end
    end
    exp_q.delete();
    load_cell(8, 8, 1);
    beats = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      @(negedge clock);
      start = (c == 0);
      if (out_if.out_valid) begin
        beats++;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++;
          $display("FAIL rst_extra: got index %0d required no beat", out_if.out_index); end
        else begin
          b = exp_q.pop_front();
          if ({out_if.out_data, out_if.out_index, out_if.out_last} !== b) begin n_fail++;
            $display("FAIL rst_post_beat: got index %0d required %0d", out_if.out_index, b.idx);
          end
        end
      end
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (!seen_done || beats != 8) begin n_fail++;
      $display("FAIL rst_post_count: got done %b beats %0d required 1/8", seen_done, beats); end
  endtask

  task automatic test_start_ignored();
    beat_t b;
    int    beats = 0;
    int    dones = 0;
    exp_q.delete();
    load_cell(5, 5, 1);
    out_if.out_ready = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clock);
      start = (c == 0) || (c == 5) || (c == 8);
      n_checks++;
      if (done !== (c == 12)) begin
        n_fail++; $display("FAIL ign_done c%0d: got %b required %b", c, done, c == 12); end
      if (done) dones++;
      if (out_if.out_valid) begin
        beats++;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++;
          $display("FAIL ign_extra: got index %0d required no beat", out_if.out_index); end
        else begin
          b = exp_q.pop_front();
          if ({out_if.out_data, out_if.out_index, out_if.out_last} !== b) begin n_fail++;
            $display("FAIL ign_beat: got index %0d required %0d", out_if.out_index, b.idx); end
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (beats != 5 || dones != 1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL ign_totals: got beats %0d dones %0d busy %b required 5/1/0",
        beats, dones, busy); end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    int    beats = 0;
    int    dones = 0;
    exp_q.delete();
    load_cell(5, 5, 2);
    out_if.out_ready = 1'b1;
    for (int c = 0; c < 80 && dones < 2; c++) begin
      @(negedge clock);
      start = (c == 0);
      if (out_if.out_valid) begin
        beats++;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++;
          $display("FAIL b2b_extra: got index %0d required no beat", out_if.out_index); end
        else begin
          b = exp_q.pop_front();
          if ({out_if.out_data, out_if.out_index, out_if.out_last} !== b) begin n_fail++;
            $display("FAIL b2b_beat: got index %0d last %b required %0d/%b", out_if.out_index,
              out_if.out_last, b.idx, b.last); end
        end
      end
      if (done) begin
        dones++;
        if (dones == 1) start = 1'b1;
      end
    end
    @(negedge clock);
    start = 1'b0;
    n_checks++;
    if (beats != 10 || dones != 2 || exp_q.size() != 0) begin n_fail++;
      $display("FAIL b2b_totals: got beats %0d dones %0d required 10/2", beats, dones); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_count_err();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_particle_reader.md
Name: cell_particle_reader

Overview:
Read-side controller for one single-port cell position RAM (address 0 = particle count, addresses 1..N = {posz,posy,posx}, 2-cycle read latency).
On a start pulse it fetches the count, then streams every particle word out over a valid/ready interface.
An internal skid FIFO absorbs in-flight reads under backpressure.
Sits between a cell memory and the force-evaluation / motion-update consumers.

Parameters:
DATA_WIDTH, 96, width of one memory word {posz,posy,posx}
PARTICLE_NUM, 220, memory depth; max legal count = PARTICLE_NUM-1
ADDR_WIDTH, 8, memory address width
FIFO_DEPTH, 4, skid FIFO entries; must be a power of 2 and >= 3 (2 in flight + 1)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin reading the cell
busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
done  out  1  one-cycle pulse after the last beat is accepted, or after count=0
count_err  out  1  sticky until next start; stored count exceeded PARTICLE_NUM-1
mem_address  out  ADDR_WIDTH  memory address, registered
mem_rden  out  1  memory read enable, registered
mem_wren  out  1  tied 0
mem_q  in  DATA_WIDTH  memory read data, valid 2 cycles after the rden cycle
out_data  out  DATA_WIDTH  particle word
out_index  out  ADDR_WIDTH  memory address of the word (1..N)
out_last  out  1  high on the final beat
out_valid  out  1  beat available
out_ready  in  1  consumer accepts; a beat transfers when out_valid && out_ready

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE, FIFO flushed, in-flight counter=0. Outputs busy, done, count_err, mem_rden, out_valid, out_last = 0; mem_address, out_data, out_index = 0. Reset mid-stream discards all in-flight data. No beat appears after release until a new start.
- States: IDLE -> CNT_RD -> CNT_WAIT -> STREAM -> DRAIN -> IDLE.
- IDLE: start is sampled in cycle 0. Next state CNT_RD; busy=1.
- CNT_RD (cycle 1): mem_address=0, mem_rden=1.
- CNT_WAIT (cycles 2-3): capture N = mem_q[ADDR_WIDTH-1:0] at the end of cycle 3.
  - If N > PARTICLE_NUM-1, clamp N to PARTICLE_NUM-1 and set count_err.
  - If N = 0: done pulses in cycle 4, busy drops with it, FSM returns to IDLE.
- STREAM: issue reads at addresses 1..N, one per cycle maximum.
  - Issue rule: a read is issued only when in_flight + fifo_count < FIFO_DEPTH.
  - in_flight counts reads whose data has not yet returned (0..2).
  - Returned data is written into the FIFO exactly 2 cycles after its rden cycle, tagged with its address and last = (addr==N).
  - First read is issued in cycle 4 at address 1.
  - Data for address 1 is written at the end of cycle 6; out_valid is first high in cycle 7.
  - With out_ready held high: one beat per cycle, no bubbles.
  - After address N is issued: mem_rden=0 and FSM moves to DRAIN.
- DRAIN: wait until in_flight=0, the FIFO is empty, and the last beat has been accepted.
  - done=1 in the cycle after the last beat handshake; busy falls in that same cycle.
  - FSM returns to IDLE.
- FIFO: never overflows by construction of the issue rule.
  - A simultaneous push and pop on a full FIFO is legal.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data, out_index, out_last remain stable while out_valid && !out_ready.
- start while busy: ignored, with no effect on state or counters.
- start in the same cycle as done: accepted; a new sequence begins.
- mem_rden is 0 in all cycles except those issuing a read. mem_address holds its last value when idle.

Test Plan:
- Memory: addr0=3, addr1..3 = 0xA1/0xA2/0xA3; out_ready=1; start at cycle 0 -> rden at addr 0 in cycle 1; beats in cycles 7, 8, 9 with index 1, 2, 3; out_last only in cycle 9; done in cycle 10.
- addr0=0; start -> no out_valid ever; done in cycle 4; busy high in cycles 1-4 only.
- N=10; out_ready toggles 1,0,0,1 repeating -> all 10 beats in order, no loss or duplication; data stable while stalled; FIFO occupancy never exceeds 4; in_flight+fifo_count never exceeds 4.
- addr0=250 with PARTICLE_NUM=220 -> count_err=1; exactly 219 beats with last index 219; count_err clears on the next start.
- N=8; assert rst_n=0 after beat 3 is accepted -> all outputs 0 immediately; no further beats; a new start yields 8 fresh beats from index 1.
- N=5; pulse start again in cycles 5 and 8 -> ignored, exactly 5 beats and one done; start coincident with done -> second sequence runs to completion.
